// File: rtl/alu_pipe_ctrl.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts under a
// three-state FSM, valid/ready on both sides, registered result and {V,C,N,Z}.
module alu_pipe_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       status
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [3:0]       sop;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;

    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic             accept;
    logic             shift_go;
    logic             last_step;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_fl;
    logic [WIDTH-1:0] step;
    logic             step_out;

    assign amt       = b[SHW-1:0];
    assign is_shift  = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    assign accept    = (state == IDLE) && in_valid;
    assign shift_go  = is_shift && (amt != '0);
    assign last_step = (cnt == SHW'(1));

    // Single-cycle path; a shift by zero lands here and simply passes a through
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_fl  = '0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                alu_res  = sum[WIDTH-1:0];
                alu_fl.c = sum[WIDTH];
                alu_fl.v = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res  = sum[WIDTH-1:0];
                alu_fl.c = sum[WIDTH];
                alu_fl.v = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_PASS: alu_res = a;
            OP_SHL, OP_SHR, OP_SRA: alu_res = a;
            default: alu_res = '0;
        endcase
        alu_fl.n = alu_res[MSB];
        alu_fl.z = (alu_res == '0);
    end

    // One-bit shift of the working register and the bit it drops
    always_comb begin
        step     = work;
        step_out = 1'b0;
        case (sop)
            OP_SHL: begin
                step     = {work[WIDTH-2:0], 1'b0};
                step_out = work[MSB];
            end
            OP_SHR: begin
                step     = {1'b0, work[WIDTH-1:1]};
                step_out = work[0];
            end
            OP_SRA: begin
                step     = {work[MSB], work[WIDTH-1:1]};
                step_out = work[0];
            end
            default: begin
                step     = work;
                step_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = shift_go ? SHIFT : DONE;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work     <= '0;
            cnt      <= '0;
            sop      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                if (shift_go) begin
                    work <= a;
                    cnt  <= amt;
                    sop  <= op;
                end else begin
                    result_q <= alu_res;
                    flags_q  <= alu_fl;
                end
            end else if (state == SHIFT) begin
                work <= step;
                cnt  <= cnt - SHW'(1);
                // Flags come from the final shifted value and the last bit dropped
                if (last_step) begin
                    result_q  <= step;
                    flags_q.v <= 1'b0;
                    flags_q.c <= step_out;
                    flags_q.n <= step[MSB];
                    flags_q.z <= (step == '0);
                end
            end
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign status    = flags_q;
    assign cout      = flags_q.c;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Bench for alu_pipe_ctrl: 64- and 8-bit instances, directed plan plus random ops
// checked against an arithmetic reference model.
module tb_alu_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_d = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    bit          sel8 = 1'b0;

    logic        iv64, ir64, ov64, co64;
    logic [63:0] res64;
    logic [3:0]  st64;
    logic        iv8, ir8, ov8, co8;
    logic [7:0]  res8;
    logic [3:0]  st8;

    logic        o_rdy, o_vld, o_co;
    logic [63:0] o_res;
    logic [3:0]  o_st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign iv64 = in_valid_d & ~sel8;
    assign iv8  = in_valid_d & sel8;

    alu_pipe_ctrl #(.WIDTH(64)) dut64 (
        .clock(clock), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(ov64), .out_ready(out_ready),
        .result(res64), .cout(co64), .status(st64)
    );

    alu_pipe_ctrl #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op), .out_valid(ov8), .out_ready(out_ready),
        .result(res8), .cout(co8), .status(st8)
    );

    assign o_rdy = sel8 ? ir8 : ir64;
    assign o_vld = sel8 ? ov8 : ov64;
    assign o_co  = sel8 ? co8 : co64;
    assign o_res = sel8 ? {56'd0, res8} : res64;
    assign o_st  = sel8 ? st8 : st64;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {V,C,N,Z, result} computed straight from the op definitions
    function automatic logic [67:0] model(input int w, input logic [3:0] f,
                                          input logic [63:0] ai, input logic [63:0] bi,
                                          input logic ci);
        logic [64:0] s;
        logic [63:0] mask, x, y, r;
        logic        c, v;
        int          sh, m;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x  = ai & mask;
        y  = bi & mask;
        m  = w - 1;
        sh = int'(bi[5:0]) % w;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        s  = '0;
        case (f)
            4'd0: begin
                s = {1'b0, x} + {1'b0, y} + 65'(ci);
                r = s[63:0] & mask;
                c = s[w];
                v = (x[m] == y[m]) && (r[m] != x[m]);
            end
            4'd1: begin
                s = {1'b0, x} + {1'b0, ~y & mask} + 65'd1;
                r = s[63:0] & mask;
                c = s[w];
                v = (x[m] != y[m]) && (r[m] != x[m]);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x & mask;
            4'd6: r = x;
            4'd7: begin
                r = (x << sh) & mask;
                if (sh > 0) c = x[w - sh];
            end
            4'd8: begin
                r = x >> sh;
                if (sh > 0) c = x[sh - 1];
            end
            4'd9: begin
                r = (x >> sh) | (x[m] ? (mask & ~(mask >> sh)) : 64'd0);
                if (sh > 0) c = x[sh - 1];
            end
            default: return {4'b0001, 64'd0};
        endcase
        return {v, c, r[m], (r == 64'd0), r};
    endfunction

    task automatic run_op(input string tag, input bit w8, input logic [3:0] f,
                          input logic [63:0] ai, input logic [63:0] bi, input logic ci,
                          input int hold, input bit use_k,
                          input logic [63:0] k_res, input logic [3:0] k_st);
        logic [67:0] e;
        logic [63:0] er;
        logic [3:0]  es;
        int w, sh, lat, elat, guard;
        w  = w8 ? 8 : 64;
        e  = model(w, f, ai, bi, ci);
        er = use_k ? k_res : e[63:0];
        es = use_k ? k_st : e[67:64];
        sh = int'(bi[5:0]) % w;
        elat = ((f == 4'd7 || f == 4'd8 || f == 4'd9) && sh != 0) ? sh + 1 : 1;
        sel8 = w8;
        guard = 0;
        while (!o_rdy && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        check({tag, "/ready"}, 64'(o_rdy), 64'd1);
        in_valid_d = 1'b1; op = f; a = ai; b = bi; cin = ci;
        @(posedge clock); #1;
        // Scramble inputs after acceptance; the DUT must ignore them
        in_valid_d = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 4'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!o_vld && lat < 200) begin
            check({tag, "/busy"}, 64'(o_rdy), 64'd0);
            @(posedge clock); #1;
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(elat));
        check({tag, "/result"}, o_res, er);
        check({tag, "/status"}, 64'(o_st), 64'(es));
        check({tag, "/cout"}, 64'(o_co), 64'(es[2]));
        check({tag, "/rdy_done"}, 64'(o_rdy), 64'd0);
        repeat (hold) begin
            @(posedge clock); #1;
            check({tag, "/hold_res"}, o_res, er);
            check({tag, "/hold_vld"}, 64'(o_vld), 64'd1);
            check({tag, "/hold_rdy"}, 64'(o_rdy), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, "/drain_vld"}, 64'(o_vld), 64'd0);
        check({tag, "/drain_rdy"}, 64'(o_rdy), 64'd1);
    endtask

    initial begin
        // Reset state of both instances
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            sel8 = (k == 1);
            #1;
            check("rst_vld", 64'(o_vld), 64'd0);
            check("rst_res", o_res, 64'd0);
            check("rst_st", 64'(o_st), 64'd0);
            check("rst_cout", 64'(o_co), 64'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        sel8 = 1'b0;
        check("rst_rdy64", 64'(o_rdy), 64'd1);

        run_op("add", 0, 4'd0, 64'd4, 64'd6, 1'b0, 1, 1, 64'd10, 4'b0000);
        run_op("sub_pos", 0, 4'd1, 64'd7, 64'd2, 1'b1, 0, 1, 64'd5, 4'b0100);
        run_op("sub_neg", 0, 4'd1, 64'd2, 64'd4, 1'b0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
        run_op("ovf8", 1, 4'd0, 64'h7F, 64'h01, 1'b0, 0, 1, 64'h80, 4'b1010);
        run_op("carry8", 1, 4'd0, 64'hFF, 64'h01, 1'b0, 0, 1, 64'h00, 4'b0101);
        run_op("shl", 0, 4'd7, 64'd2, 64'd3, 1'b0, 0, 1, 64'd16, 4'b0000);
        run_op("shr", 0, 4'd8, 64'h8000_0000_0000_0001, 64'd1, 1'b0, 0, 1,
               64'h4000_0000_0000_0000, 4'b0100);
        run_op("sra", 0, 4'd9, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 0, 1,
               64'hF800_0000_0000_0000, 4'b0010);
        run_op("shl0", 0, 4'd7, 64'h55, 64'h40, 1'b0, 0, 1, 64'h55, 4'b0000);
        run_op("illegal", 0, 4'd12, 64'd3, 64'd3, 1'b1, 0, 1, 64'd0, 4'b0001);
        run_op("bp", 0, 4'd0, 64'd1, 64'd1, 1'b0, 3, 1, 64'd2, 4'b0000);

        // Reset while a long shift is in flight
        sel8 = 1'b0;
        in_valid_d = 1'b1; op = 4'd7; a = 64'd1; b = 64'd40; cin = 1'b0;
        @(posedge clock); #1;
        in_valid_d = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("mid_busy", 64'(o_vld), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_vld", 64'(o_vld), 64'd0);
        check("mid_rst_res", o_res, 64'd0);
        check("mid_rst_st", 64'(o_st), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_rdy", 64'(o_rdy), 64'd1);
        run_op("pass_after", 0, 4'd6, 64'd9, 64'd0, 1'b0, 0, 1, 64'd9, 4'b0000);

        for (int i = 0; i < 40; i++)
            run_op("rnd64", 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom), int'($urandom_range(0, 2)), 0, '0, '0);
        for (int i = 0; i < 40; i++)
            run_op("rnd8", 1, 4'($urandom_range(0, 15)), 64'($urandom_range(0, 255)),
                   64'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 2)), 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
